// File: rtl/mux16.sv
// Two-input data mux with a combinational output and a
// one-deep valid/ready output register that captures the mux result.
module mux16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d0,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid,
    output logic             in_ready
);

    logic capture;

    // Plain ternary: an unknown sel merges d0/d1 bitwise in simulation.
    always_comb begin
        out = sel ? d1 : d0;
    end

    // Slot is free when empty or being drained this cycle.
    always_comb begin
        in_ready = !out_valid || out_ready;
        capture  = in_valid && in_ready;
    end

    // Output register: reset wins, then capture, then drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (capture) begin
            out_q     <= out;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux16.sv
// Self-checking bench for mux16: directed scenarios plus a randomized
// run compared against a transfer-level model of the output slot.
module tb_mux16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] d1;
    logic [W-1:0] d0;
    logic         sel;
    logic [W-1:0] out;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] out_q;
    logic         out_valid;
    logic         in_ready;

    int errors = 0;
    int checks = 0;

    mux16 #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .d1(d1),
        .d0(d0),
        .sel(sel),
        .out(out),
        .in_valid(in_valid),
        .out_ready(out_ready),
        .out_q(out_q),
        .out_valid(out_valid),
        .in_ready(in_ready)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(string name, logic [W-1:0] got,
                         logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic chk_b(string name, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        d0 = 16'h1111;
        d1 = 16'h2222;
        sel = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_w("reset out_q", out_q, 16'h0000);
        chk_b("reset out_valid", out_valid, 1'b0);
        chk_b("reset in_ready", in_ready, 1'b1);
    endtask

    task automatic test_comb();
        logic [W-1:0] t0 [6];
        logic [W-1:0] t1 [6];
        logic         ts [6];
        logic [W-1:0] te [6];
        t0 = '{16'h0000, 16'h0000, 16'h9876,
               16'h9876, 16'hAAAA, 16'hAAAA};
        t1 = '{16'h1234, 16'h1234, 16'h0000,
               16'h0000, 16'h5555, 16'h5555};
        ts = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        te = '{16'h0000, 16'h1234, 16'h9876,
               16'h0000, 16'hAAAA, 16'h5555};
        for (int i = 0; i < 6; i++) begin
            d0 = t0[i];
            d1 = t1[i];
            sel = ts[i];
            #1;
            chk_w($sformatf("comb out[%0d]", i), out, te[i]);
        end
    endtask

    task automatic test_registered();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b1;
        d0 = 16'hAAAA;
        d1 = 16'h5555;
        sel = 1'b1;
        tick();
        chk_w("reg out_q", out_q, 16'h5555);
        chk_b("reg out_valid", out_valid, 1'b1);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        d1 = 16'h1234;
        sel = 1'b1;
        #1;
        chk_b("bp in_ready", in_ready, 1'b0);
        tick();
        chk_w("bp hold out_q", out_q, 16'h5555);
        chk_b("bp hold valid", out_valid, 1'b1);
        out_ready = 1'b1;
        #1;
        chk_b("bp in_ready up", in_ready, 1'b1);
        tick();
        chk_w("bp new out_q", out_q, 16'h1234);
        chk_b("bp new valid", out_valid, 1'b1);
    endtask

    task automatic test_drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        d1 = 16'hFFFF;
        d0 = 16'hEEEE;
        tick();
        chk_b("drain valid", out_valid, 1'b0);
        chk_w("drain out_q", out_q, 16'h1234);
        chk_b("drain in_ready", in_ready, 1'b1);
    endtask

    task automatic test_reset_priority();
        in_valid = 1'b1;
        out_ready = 1'b0;
        d0 = 16'hAAAA;
        sel = 1'b0;
        tick();
        chk_b("rp preload", out_valid, 1'b1);
        reset = 1'b1;
        d0 = 16'h9876;
        d1 = 16'h0F0F;
        #1;
        chk_w("rp out before", out, 16'h9876);
        tick();
        chk_w("rp out_q", out_q, 16'h0000);
        chk_b("rp out_valid", out_valid, 1'b0);
        chk_w("rp out after", out, 16'h9876);
        reset = 1'b0;
        in_valid = 1'b0;
    endtask

    // Model: one slot holding at most one result. Each edge, a held
    // result is consumed if out_ready; then a new one may enter if the
    // slot is (now) empty. Reset empties the slot and zeroes its data.
    task automatic test_random();
        logic [W-1:0] m_q;
        logic         m_full;
        logic [W-1:0] pick;
        logic         took;
        m_q = out_q;
        m_full = out_valid;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 39) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            d0 = W'($urandom);
            d1 = W'($urandom);
            sel = $urandom_range(0, 1) == 1;
            #1;
            pick = (sel == 1'b1) ? d1 : d0;
            chk_w("rnd out", out, pick);
            chk_b("rnd in_ready", in_ready,
                  (m_full == 1'b0) || (out_ready == 1'b1));
            took = m_full && out_ready;
            if (reset) begin
                m_q = '0;
                m_full = 1'b0;
            end else begin
                if (took)
                    m_full = 1'b0;
                if (in_valid && !m_full) begin
                    m_q = pick;
                    m_full = 1'b1;
                end
            end
            tick();
            chk_w("rnd out_q", out_q, m_q);
            chk_b("rnd out_valid", out_valid, m_full);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        d0 = '0;
        d1 = '0;
        sel = 1'b0;
        #2;
        test_reset();
        test_comb();
        test_registered();
        test_backpressure();
        test_drain();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
